// File: rtl/hs_src_arb.sv
// hs_src_arb: round-robin arbiter that hands one source channel at a time to a four-phase req/ack link.
// Define HS_TIMEOUT_EN to abandon a request whose ack has not arrived within TIMEOUT_CYC cycles.
module hs_src_arb #(
    parameter int DATA_WIDTH  = 8,
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGE  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk_source,
    input  logic                         rst_source,
    input  logic [CH_NUM-1:0]            sig_pulse_source,
    input  logic [CH_NUM*DATA_WIDTH-1:0] sig_data_source,
    output logic [CH_NUM-1:0]            sync_busy,
    output logic                         req_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [$clog2(CH_NUM)-1:0]    ch_id_out,
    input  logic                         ack_in,
    output logic                         done_pulse,
    output logic [CH_NUM-1:0]            drop_err,
    output logic                         timeout_err
);
    localparam int IDW = $clog2(CH_NUM);

    typedef enum logic [1:0] {IDLE, REQ, ACK_LOW} state_t;

    state_t                state;
    logic [SYNC_STAGE-1:0] ack_sync;
    logic                  ack_s;
    logic [CH_NUM-1:0]     pending;
    logic [DATA_WIDTH-1:0] latch [CH_NUM];
    logic [IDW-1:0]        last_grant;
    logic [IDW-1:0]        winner;
    logic                  found;
    logic                  grant;
    logic [CH_NUM-1:0]     inflight;
    logic [CH_NUM-1:0]     clr;
    logic [CH_NUM-1:0]     accept;

`ifdef HS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign ack_s = ack_sync[SYNC_STAGE-1];

    always_ff @(posedge clk_source) begin
        if (rst_source) ack_sync <= '0;
        else            ack_sync <= {ack_sync[SYNC_STAGE-2:0], ack_in};
    end

    always_comb begin
        inflight = '0;
        if (state != IDLE) inflight[ch_id_out] = 1'b1;
    end

    assign sync_busy = pending | inflight;
    assign accept    = sig_pulse_source & ~sync_busy;

    // Search starts one past the previous winner so every pending channel is reached within CH_NUM grants.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= CH_NUM; k++) begin
            idx = (int'(last_grant) + k) % CH_NUM;
            if (!found && pending[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // A remote ack still high from a previous transfer blocks new grants.
    assign grant = (state == IDLE) && found && !ack_s;

    always_comb begin
        clr = '0;
        if (grant) clr[winner] = 1'b1;
    end

    always_ff @(posedge clk_source) begin
        if (rst_source) begin
            state      <= IDLE;
            pending    <= '0;
            req_out    <= 1'b0;
            data_out   <= '0;
            ch_id_out  <= '0;
            done_pulse <= 1'b0;
            drop_err   <= '0;
            last_grant <= IDW'(CH_NUM - 1);
            for (int i = 0; i < CH_NUM; i++) latch[i] <= '0;
`ifdef HS_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            done_pulse <= 1'b0;
            drop_err   <= sig_pulse_source & sync_busy;
            pending    <= (pending | accept) & ~clr;
            for (int i = 0; i < CH_NUM; i++)
                if (accept[i]) latch[i] <= sig_data_source[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef HS_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= REQ;
                        req_out    <= 1'b1;
                        data_out   <= latch[winner];
                        ch_id_out  <= winner;
                        last_grant <= winner;
`ifdef HS_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state      <= ACK_LOW;
                        req_out    <= 1'b0;
                        done_pulse <= 1'b1;
                    end
`ifdef HS_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state       <= ACK_LOW;
                        req_out     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ACK_LOW: begin
                    if (!ack_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs_src_arb.sv
// Self-checking bench for hs_src_arb: cycle model plus directed handshake scenarios and random traffic.
module tb_hs_src_arb;
    localparam int DW  = 8;
    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int TO  = 16;
    localparam int IDW = $clog2(CH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     pulse = '0;
    logic [CH*DW-1:0]  din = '0;
    logic [CH-1:0]     busy;
    logic              req;
    logic [DW-1:0]     dout;
    logic [IDW-1:0]    id;
    logic              ack = 1'b0;
    logic              done;
    logic [CH-1:0]     drop;
    logic              to;

    always #5 clk = ~clk;

    hs_src_arb #(.DATA_WIDTH(DW), .CH_NUM(CH), .SYNC_STAGE(SS), .TIMEOUT_CYC(TO)) dut (
        .clk_source(clk), .rst_source(rst), .sig_pulse_source(pulse), .sig_data_source(din),
        .sync_busy(busy), .req_out(req), .data_out(dout), .ch_id_out(id), .ack_in(ack),
        .done_pulse(done), .drop_err(drop), .timeout_err(to)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for ack, 2 waiting for ack release.
    int             m_phase = 0;
    bit             m_req = 0, m_done = 0, m_to = 0;
    bit [CH-1:0]    m_pend = '0, m_drop = '0;
    logic [DW-1:0]  m_lat [CH];
    logic [DW-1:0]  m_data = '0;
    int             m_id = 0, m_last = CH - 1, m_cnt = 0;
    bit             mq[$];

    function automatic logic [CH-1:0] m_busy();
        logic [CH-1:0] b;
        b = m_pend;
        if (m_phase != 0) b[m_id] = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin : model
        logic [CH-1:0] b, old;
        bit            as;
        int            best, bd, d;
        if (rst) begin
            m_phase = 0; m_req = 0; m_done = 0; m_to = 0; m_pend = '0; m_drop = '0;
            m_data = '0; m_id = 0; m_last = CH - 1; m_cnt = 0;
            for (int i = 0; i < CH; i++) m_lat[i] = '0;
            mq.delete();
            for (int k = 0; k < SS; k++) mq.push_back(1'b0);
        end else begin
            b = m_busy(); old = m_pend; as = mq[0];
            m_drop = pulse & b; m_done = 0; m_to = 0;
            for (int i = 0; i < CH; i++)
                if (pulse[i] && !b[i]) begin m_pend[i] = 1'b1; m_lat[i] = din[i*DW +: DW]; end
            case (m_phase)
                0: if (old != 0 && !as) begin
                    best = 0; bd = CH;
                    for (int i = 0; i < CH; i++)
                        if (old[i]) begin
                            d = (i - m_last - 1 + 2 * CH) % CH;
                            if (d < bd) begin bd = d; best = i; end
                        end
                    m_phase = 1; m_req = 1; m_id = best; m_data = m_lat[best];
                    m_pend[best] = 1'b0; m_last = best; m_cnt = 0;
                end
                1: if (as) begin m_phase = 2; m_req = 0; m_done = 1; end
`ifdef HS_TIMEOUT_EN
                   else if (m_cnt == TO - 1) begin m_phase = 2; m_req = 0; m_to = 1; end
                   else m_cnt++;
`endif
                default: if (!as) m_phase = 0;
            endcase
            void'(mq.pop_front());
            mq.push_back(ack);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_out", req, m_req);
            check("data_out", dout, m_data);
            check("ch_id_out", id, m_id);
            check("done_pulse", done, m_done);
            check("drop_err", drop, m_drop);
            check("timeout_err", to, m_to);
            check("sync_busy", busy, m_busy());
        end
    end

    // Remote side: 0 = auto four-phase responder, 1 = ack forced high, 2 = ack held low.
    int ack_mode = 0, ack_dly = 3, ack_wait = 0;
    bit rand_dly = 0;
    always begin
        @(negedge clk); #1;
        case (ack_mode)
            1: ack = 1'b1;
            2: ack = 1'b0;
            default: begin
                if (req != ack) begin
                    if (ack_wait >= ack_dly) begin
                        ack = req; ack_wait = 0;
                        if (rand_dly) ack_dly = $urandom_range(0, 4);
                    end else ack_wait++;
                end else ack_wait = 0;
            end
        endcase
    end

    int         gq[$];
    logic [7:0] dq[$];
    bit         rec_en = 0, seen_ee = 0;
    logic       req_q = 1'b0;
    always @(negedge clk) begin
        if (rec_en && req && !req_q) begin gq.push_back(int'(id)); dq.push_back(dout); end
        if (req && dout == 8'hEE) seen_ee = 1;
        req_q = req;
    end

    task automatic do_reset();
        rst = 1; pulse = '0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic idle_wait(input string nm);
        int n = 0;
        while (!(busy == 0 && !req && !ack) && n < 300) begin @(negedge clk); n++; end
        check({nm, "_idle_reached"}, n < 300, 1);
        repeat (SS + 2) @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!req && n < 50) begin @(negedge clk); n++; end
        check({nm, "_req_seen"}, n < 50, 1);
    endtask

    initial begin
        int dc, k, rc;
        repeat (3) @(negedge clk);
        rst = 0; chk_en = 1;
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_data", dout, 0);

        // single transfer on ch2
        ack_mode = 0; ack_dly = 3;
        @(negedge clk); pulse = 4'b0100; din[2*DW +: DW] = 8'hA5;
        @(negedge clk); pulse = '0;
        check("s1_pending", busy[2], 1);
        check("s1_req_early", req, 0);
        @(negedge clk);
        check("s1_req_rise", req, 1);
        check("s1_data", dout, 8'hA5);
        check("s1_id", id, 2);
        dc = 0;
        repeat (25) begin @(negedge clk); if (done) dc++; end
        check("s1_done_count", dc, 1);
        idle_wait("s1");
        check("s1_busy2_low", busy[2], 0);

        // four simultaneous requests
        do_reset();
        gq.delete(); dq.delete(); rec_en = 1;
        @(negedge clk); pulse = 4'b1111; din = 32'h13121110;
        @(negedge clk); pulse = '0;
        check("s2_all_pending", busy, 4'b1111);
        idle_wait("s2");
        rec_en = 0;
        check("s2_grants", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            check("s2_order", gq[i], i);
            check("s2_data", dq[i], 8'h10 + i);
        end

        // second pulse on ch1 while it is in flight
        do_reset();
        seen_ee = 0; ack_dly = 4;
        @(negedge clk); pulse = 4'b0010; din[DW +: DW] = 8'h55;
        @(negedge clk); pulse = '0;
        wait_req("s3");
        check("s3_data", dout, 8'h55);
        pulse = 4'b0010; din[DW +: DW] = 8'hEE;
        @(negedge clk); pulse = '0;
        check("s3_drop_hi", drop, 4'b0010);
        @(negedge clk);
        check("s3_drop_lo", drop, 0);
        idle_wait("s3");
        check("s3_no_ee", seen_ee, 0);

        // timeout behaviour
        do_reset();
        ack_mode = 2;
        @(negedge clk); pulse = 4'b0010; din[DW +: DW] = 8'h3C;
        @(negedge clk); pulse = '0;
        wait_req("s4");
`ifdef HS_TIMEOUT_EN
        k = 0; dc = 0;
        while (req && k < 100) begin @(negedge clk); k++; if (done) dc++; end
        check("s4_timeout_len", k, TO);
        check("s4_timeout_err", to, 1);
        check("s4_no_done", dc, 0);
`else
        dc = 0;
        repeat (40) begin @(negedge clk); if (done || to) dc++; end
        check("s4_req_held", req, 1);
        check("s4_no_done_or_to", dc, 0);
`endif
        ack_mode = 0; ack_dly = 2;
        idle_wait("s4");

        // reset in the middle of a transfer with another channel pending
        do_reset();
        ack_mode = 2;
        @(negedge clk); pulse = 4'b1001; din = 32'h77000066;
        @(negedge clk); pulse = '0;
        wait_req("s5");
        rst = 1;
        @(negedge clk);
        check("s5_req_low", req, 0);
        check("s5_busy_low", busy, 0);
        check("s5_no_done", done, 0);
        rst = 0;
        dc = 0;
        repeat (6) begin @(negedge clk); if (done || req) dc++; end
        check("s5_quiet_after", dc, 0);
        ack_mode = 0;

        // ack high while idle blocks the grant
        do_reset();
        ack_mode = 1;
        repeat (SS + 3) @(negedge clk);
        pulse = 4'b0001; din[0 +: DW] = 8'h81;
        @(negedge clk); pulse = '0;
        rc = 0;
        repeat (8) begin @(negedge clk); if (req) rc++; end
        check("s6_no_grant", rc, 0);
        check("s6_pending", busy[0], 1);
        ack_mode = 2;
        repeat (SS) @(negedge clk);
        check("s6_still_blocked", req, 0);
        @(negedge clk);
        check("s6_grant", req, 1);
        check("s6_data", dout, 8'h81);
        ack_mode = 0;
        idle_wait("s6");

        // random traffic against the model
        do_reset();
        rand_dly = 1; ack_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < CH; i++) pulse[i] = ($urandom_range(0, 2) == 0);
            din = $urandom;
        end
        @(negedge clk); pulse = '0; rst = 0;
        idle_wait("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1);
    end
endmodule
